// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Two-source arbiter for the single write port of the 32-bit packet FIFO
// (write clock domain). It grants one source at a time for a burst of
// BURST_LEN words. Acceptance is throttled on the FIFO fill level. The FIFO
// write strobe and data are registered.
//
// Ports
//   clk, rst_n         write-domain clock, asynchronous active-low reset
//   srcN_vld/data      source N word offer (N = 0, 1)
//   srcN_rdy           source N word accepted this cycle when srcN_vld = 1
//   fifo_wrusedw       FIFO write-side used-word count
//   fifo_wrreq/wrdata  registered FIFO write strobe and data
//   grant              one-hot current owner, 2'b00 = idle
//
// Configuration macro
//   ARB_FIXED_PRIO_EN  when defined, src0 always wins ties (fixed priority).
//                      When undefined (default), ties are resolved round-robin.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int DW        = 32,
    parameter int AW        = 6,
    parameter int BURST_LEN = 4,
    parameter int FULL_TH   = 61
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src0_vld,
    input  logic [DW-1:0] src0_data,
    output logic          src0_rdy,
    input  logic          src1_vld,
    input  logic [DW-1:0] src1_data,
    output logic          src1_rdy,
    input  logic [AW-1:0] fifo_wrusedw,
    output logic          fifo_wrreq,
    output logic [DW-1:0] fifo_wrdata,
    output logic [1:0]    grant
);

    // The state encoding matches the one-hot grant value, so grant is the state register itself.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam int             CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0]  LAST_CNT  = CW'(BURST_LEN - 1);
    // One extra bit so that a threshold equal to the FIFO depth is still representable.
    localparam logic [AW:0]    FULL_TH_W = (AW+1)'(FULL_TH);

    state_t          state_q,       state_d;
    logic [CW-1:0]   burst_cnt_q,   burst_cnt_d;
    logic            fifo_wrreq_q,  fifo_wrreq_d;
    logic [DW-1:0]   fifo_wrdata_q, fifo_wrdata_d;
`ifndef ARB_FIXED_PRIO_EN
    // 0: src0 was served last, 1: src1 was served last.
    logic            last_ptr_q,    last_ptr_d;
`endif

    logic            space_ok;
    logic            xfer0;
    logic            xfer1;
    logic            burst_done;
    state_t          tie_winner;
    state_t          g0_end_next;
    state_t          g1_end_next;

    // rdy depends only on ownership and fill level. It never depends on vld,
    // so there is no combinational loop through a source's handshake.
    assign space_ok   = ({1'b0, fifo_wrusedw} < FULL_TH_W);
    assign src0_rdy   = (state_q == G0) && space_ok;
    assign src1_rdy   = (state_q == G1) && space_ok;
    assign xfer0      = src0_vld && src0_rdy;
    assign xfer1      = src1_vld && src1_rdy;
    assign burst_done = (burst_cnt_q == LAST_CNT);

    assign fifo_wrreq  = fifo_wrreq_q;
    assign fifo_wrdata = fifo_wrdata_q;
    assign grant       = state_q;

`ifdef ARB_FIXED_PRIO_EN
    // src0 wins every contest. At the end of a burst, src1 gets the port only if src0 is silent.
    assign tie_winner  = G0;
    assign g0_end_next = src0_vld ? G0 : (src1_vld ? G1 : IDLE);
    assign g1_end_next = src0_vld ? G0 : (src1_vld ? G1 : IDLE);
`else
    // Round-robin: the source not served last wins a tie. At the end of a burst,
    // the other source takes over directly, with no idle bubble.
    assign tie_winner  = last_ptr_q ? G0 : G1;
    assign g0_end_next = src1_vld ? G1 : (src0_vld ? G0 : IDLE);
    assign g1_end_next = src0_vld ? G0 : (src1_vld ? G1 : IDLE);
`endif

    // Next-state logic. While space_ok is low, no transfer can happen, so the
    // state and burst count hold on their own. The write data holds its last
    // value between strobes.
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        fifo_wrreq_d  = 1'b0;
        fifo_wrdata_d = fifo_wrdata_q;
`ifndef ARB_FIXED_PRIO_EN
        last_ptr_d    = last_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (src0_vld && src1_vld) begin
                    state_d = tie_winner;
                end else if (src0_vld) begin
                    state_d = G0;
                end else if (src1_vld) begin
                    state_d = G1;
                end
            end
            G0: begin
                if (xfer0) begin
                    fifo_wrreq_d  = 1'b1;
                    fifo_wrdata_d = src0_data;
                    if (burst_done) begin
                        burst_cnt_d = '0;
                        state_d     = g0_end_next;
`ifndef ARB_FIXED_PRIO_EN
                        last_ptr_d  = 1'b0;
`endif
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            G1: begin
                if (xfer1) begin
                    fifo_wrreq_d  = 1'b1;
                    fifo_wrdata_d = src1_data;
                    if (burst_done) begin
                        burst_cnt_d = '0;
                        state_d     = g1_end_next;
`ifndef ARB_FIXED_PRIO_EN
                        last_ptr_d  = 1'b1;
`endif
                    end else begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // State and output registers. Reset drops any partial burst; it is not resumed.
    // last_ptr resets to "src1 served last", so src0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            burst_cnt_q   <= '0;
            fifo_wrreq_q  <= 1'b0;
            fifo_wrdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_ptr_q    <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            fifo_wrreq_q  <= fifo_wrreq_d;
            fifo_wrdata_q <= fifo_wrdata_d;
`ifndef ARB_FIXED_PRIO_EN
            last_ptr_q    <= last_ptr_d;
`endif
        end
    end

endmodule
